// File: rtl/midi_pkg.sv
// Shared MIDI receive definitions: receiver state encoding and protocol constants.
package midi_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } rx_state_t;

   localparam int MIDI_BAUD          = 31250;
   localparam int MIDI_BITS_PER_BYTE = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; both flops reset to RESET_VAL.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic n_reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/midi_rx_ctrl.sv
// MIDI 8N1 receive controller: finds start bits, samples mid-bit and strobes each data
// bit into an external shift register, then flags byte completion or a bad stop bit.
module midi_rx_ctrl
   import midi_pkg::*;
#(
   parameter int CLK_FREQ_HZ = 50_000_000,
   parameter int BAUD        = MIDI_BAUD
) (
   input  logic      clk,
   input  logic      n_reset,
   input  logic      serial_in,
   output logic      shift_en,
   output logic      data_bit,
   output logic      byte_ready,
   output logic      framing_error,
   output logic      busy,
   output rx_state_t state_dbg
);

   localparam int CYCLES_PER_BIT = CLK_FREQ_HZ / BAUD;
   localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
   localparam int TW             = $clog2(CYCLES_PER_BIT);

   localparam logic [TW-1:0] BIT_LAST  = TW'(CYCLES_PER_BIT - 1);
   localparam logic [TW-1:0] HALF_LAST = TW'(HALF_BIT - 1);
   localparam logic [2:0]    LAST_BIT  = 3'(MIDI_BITS_PER_BYTE - 1);

   if (CYCLES_PER_BIT < 4) begin : g_cpb_check
      $error("midi_rx_ctrl: CYCLES_PER_BIT must be at least 4");
   end

   rx_state_t       state, state_nxt;
   logic            rx_s, rx_d;
   logic [TW-1:0]   timer;
   logic [2:0]      bit_cnt;

   logic            timer_clr, bit_clr, bit_inc;
   logic            shift_nxt, data_nxt, ready_nxt, ferr_nxt;

   sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clk     (clk),
      .n_reset (n_reset),
      .d       (serial_in),
      .q       (rx_s)
   );

   assign state_dbg = state;

   // State register plus the datapath that follows it (timer, bit counter, outputs).
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state         <= IDLE;
         rx_d          <= 1'b1;
         timer         <= '0;
         bit_cnt       <= '0;
         shift_en      <= 1'b0;
         data_bit      <= 1'b1;
         byte_ready    <= 1'b0;
         framing_error <= 1'b0;
         busy          <= 1'b0;
      end else begin
         state         <= state_nxt;
         rx_d          <= rx_s;
         timer         <= timer_clr ? '0 : timer + TW'(1);
         if (bit_clr) begin
            bit_cnt <= '0;
         end else if (bit_inc) begin
            bit_cnt <= bit_cnt + 3'd1;
         end
         shift_en      <= shift_nxt;
         data_bit      <= data_nxt;
         byte_ready    <= ready_nxt;
         framing_error <= ferr_nxt;
         busy          <= (state_nxt != IDLE);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (rx_d && !rx_s) state_nxt = START;
         START:     if (timer == HALF_LAST) state_nxt = rx_s ? IDLE : DATA;
         DATA:      if (timer == BIT_LAST && bit_cnt == LAST_BIT) state_nxt = STOP;
         STOP:      if (timer == BIT_LAST) state_nxt = rx_s ? IDLE : WAIT_HIGH;
         WAIT_HIGH: if (rx_s) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // The timer is held at zero outside the timed states so it can never wrap.
   always_comb begin
      timer_clr = 1'b0;
      bit_clr   = 1'b0;
      bit_inc   = 1'b0;
      shift_nxt = 1'b0;
      data_nxt  = data_bit;
      ready_nxt = 1'b0;
      ferr_nxt  = 1'b0;
      case (state)
         IDLE:      timer_clr = 1'b1;
         START: begin
            if (timer == HALF_LAST) begin
               timer_clr = 1'b1;
               bit_clr   = 1'b1;
            end
         end
         DATA: begin
            if (timer == BIT_LAST) begin
               timer_clr = 1'b1;
               bit_inc   = 1'b1;
               shift_nxt = 1'b1;
               data_nxt  = rx_s;
            end
         end
         STOP: begin
            if (timer == BIT_LAST) begin
               timer_clr = 1'b1;
               ready_nxt = rx_s;
               ferr_nxt  = !rx_s;
            end
         end
         WAIT_HIGH: timer_clr = 1'b1;
         default:   timer_clr = 1'b1;
      endcase
   end

endmodule
